// File: rtl/count_sequence_checker.sv
// Cycle-accurate checker for a loadable up-counter: predicts the next
// count from the observed controls and flags and counts every deviation.
module count_sequence_checker #(
    parameter int WIDTH        = 4,
    parameter int ERR_W        = 8,
    parameter int RESYNC_LIMIT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mon_en,
    input  logic             clear_err,
    input  logic             dut_rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] expected,
    output logic             mismatch,
    output logic             err_sticky,
    output logic [ERR_W-1:0] err_count,
    output logic             wrap_pulse,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        CHECK  = 2'd1,
        RESYNC = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;
    localparam logic [3:0]       LIMIT   = 4'(RESYNC_LIMIT);

    state_t           state_q;
    state_t           state_d;
    logic [3:0]       miss_q;
    logic [3:0]       miss_d;
    logic [WIDTH-1:0] pred;
    logic             incr_wrap;
    logic             bad;

    logic [WIDTH-1:0] expected_d;
    logic             wrap_d;
    logic [ERR_W-1:0] err_count_d;
    logic             err_sticky_d;

    // Prediction is always built from the observed count, never from expected.
    always_comb begin
        pred = count + WIDTH'(1);
        if (dut_rst) begin
            pred = '0;
        end else if (load) begin
            pred = load_val;
        end
    end

    assign incr_wrap = !dut_rst && !load && (count == CNT_MAX);
    assign bad = mon_en && (state_q == CHECK) && (count != expected);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= INIT;
            miss_q  <= '0;
        end else begin
            state_q <= state_d;
            miss_q  <= miss_d;
        end
    end

    always_comb begin
        state_d = state_q;
        miss_d  = miss_q;
        if (!mon_en) begin
            state_d = INIT;
            miss_d  = '0;
        end else begin
            unique case (state_q)
                INIT: begin
                    state_d = CHECK;
                    miss_d  = '0;
                end
                CHECK: begin
                    if (bad) begin
                        miss_d = miss_q + 4'd1;
                        if (miss_d >= LIMIT) begin
                            state_d = RESYNC;
                        end
                    end else begin
                        miss_d = '0;
                    end
                end
                RESYNC: begin
                    state_d = CHECK;
                    miss_d  = '0;
                end
                default: begin
                    state_d = INIT;
                    miss_d  = '0;
                end
            endcase
        end
    end

    // Clear beats a coincident mismatch; the pulse itself is still issued.
    always_comb begin
        expected_d   = expected;
        wrap_d       = 1'b0;
        err_count_d  = err_count;
        err_sticky_d = err_sticky;
        if (mon_en) begin
            expected_d = pred;
            wrap_d     = incr_wrap;
        end
        if (clear_err) begin
            err_count_d  = '0;
            err_sticky_d = 1'b0;
        end else if (bad) begin
            err_sticky_d = 1'b1;
            if (err_count != ERR_MAX) begin
                err_count_d = err_count + ERR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            expected   <= '0;
            mismatch   <= 1'b0;
            err_sticky <= 1'b0;
            err_count  <= '0;
            wrap_pulse <= 1'b0;
        end else begin
            expected   <= expected_d;
            mismatch   <= bad;
            err_sticky <= err_sticky_d;
            err_count  <= err_count_d;
            wrap_pulse <= wrap_d;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_count_sequence_checker.sv
// Bench for count_sequence_checker: directed scenarios with literal pins,
// then randomized counter traffic against a behavioural reference.
module tb_count_sequence_checker;

    localparam int LIMIT = 3;

    logic       clk;
    logic       rst;
    logic       mon_en;
    logic       clear_err;
    logic       dut_rst;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] count;

    logic [3:0] expected;
    logic       mismatch;
    logic       err_sticky;
    logic [7:0] err_count;
    logic       wrap_pulse;
    logic [1:0] state;

    logic [3:0] s_expected;
    logic       s_mismatch;
    logic       s_err_sticky;
    logic [1:0] s_err_count;
    logic       s_wrap_pulse;
    logic [1:0] s_state;

    int checks = 0;
    int errors = 0;

    count_sequence_checker #(.WIDTH(4), .ERR_W(8), .RESYNC_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst), .mon_en(mon_en), .clear_err(clear_err),
        .dut_rst(dut_rst), .load(load), .load_val(load_val), .count(count),
        .expected(expected), .mismatch(mismatch), .err_sticky(err_sticky),
        .err_count(err_count), .wrap_pulse(wrap_pulse), .state(state)
    );

    count_sequence_checker #(.WIDTH(4), .ERR_W(2), .RESYNC_LIMIT(LIMIT)) dut_s (
        .clk(clk), .rst(rst), .mon_en(mon_en), .clear_err(clear_err),
        .dut_rst(dut_rst), .load(load), .load_val(load_val), .count(count),
        .expected(s_expected), .mismatch(s_mismatch), .err_sticky(s_err_sticky),
        .err_count(s_err_count), .wrap_pulse(s_wrap_pulse), .state(s_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input int want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, want, $time);
        end
    endtask

    // Reference: mode 0=idle,1=checking,2=resync; run = consecutive misses.
    int m_exp, m_mis, m_sticky, m_err8, m_err2, m_wrap, m_mode, m_run;
    int p;
    bit is_bad;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_exp = 0; m_mis = 0; m_sticky = 0; m_err8 = 0;
            m_err2 = 0; m_wrap = 0; m_mode = 0; m_run = 0;
        end else begin
            if (dut_rst) p = 0;
            else if (load) p = int'(load_val);
            else p = (int'(count) + 1) % 16;
            is_bad = mon_en && m_mode == 1 && int'(count) != m_exp;
            m_mis = is_bad ? 1 : 0;
            if (clear_err) begin
                m_err8 = 0; m_err2 = 0; m_sticky = 0;
            end else if (is_bad) begin
                m_sticky = 1;
                if (m_err8 < 255) m_err8++;
                if (m_err2 < 3) m_err2++;
            end
            if (!mon_en) begin
                m_mode = 0; m_run = 0; m_wrap = 0;
            end else begin
                m_wrap = (!dut_rst && !load && count == 4'd15) ? 1 : 0;
                m_exp = p;
                if (m_mode == 1) begin
                    m_run = is_bad ? m_run + 1 : 0;
                    if (m_run == LIMIT) begin
                        m_mode = 2; m_run = 0;
                    end
                end else begin
                    m_mode = 1; m_run = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("expected", 32'(expected), m_exp);
        chk("mismatch", 32'(mismatch), m_mis);
        chk("err_sticky", 32'(err_sticky), m_sticky);
        chk("err_count", 32'(err_count), m_err8);
        chk("wrap_pulse", 32'(wrap_pulse), m_wrap);
        chk("state", 32'(state), m_mode);
        chk("s_err_count", 32'(s_err_count), m_err2);
        chk("s_err_sticky", 32'(s_err_sticky), m_sticky);
        chk("s_expected", 32'(s_expected), m_exp);
        chk("s_state", 32'(s_state), m_mode);
    end

    task automatic drive(input bit dr, input bit ld, input int lv, input int cnt,
                         input bit en, input bit clr);
        dut_rst   = dr;
        load      = ld;
        load_val  = lv[3:0];
        count     = cnt[3:0];
        mon_en    = en;
        clear_err = clr;
        @(negedge clk);
    endtask

    int tc, cnt, stuck, stuck_val, lv;
    bit dr, ld, en, clr;

    initial begin
        rst = 1'b0; mon_en = 1'b0; clear_err = 1'b0;
        dut_rst = 1'b0; load = 1'b0; load_val = '0; count = '0;
        @(negedge clk);
        @(negedge clk);
        chk("lit_reset_state", 32'(state), 0);
        chk("lit_reset_expected", 32'(expected), 0);
        rst = 1'b1;

        // load 5 then count
        drive(0, 1, 5, 0, 1, 0);
        chk("lit_load_state", 32'(state), 1);
        chk("lit_load_exp", 32'(expected), 5);
        drive(0, 0, 0, 5, 1, 0);
        drive(0, 0, 0, 6, 1, 0);
        drive(0, 0, 0, 7, 1, 0);
        chk("lit_count_exp", 32'(expected), 8);
        chk("lit_count_err", 32'(err_count), 0);

        // wrap by increment, then load of 0 without wrap
        drive(0, 1, 14, 8, 1, 0);
        drive(0, 0, 0, 14, 1, 0);
        chk("lit_prewrap", 32'(wrap_pulse), 0);
        drive(0, 0, 0, 15, 1, 0);
        chk("lit_wrap_exp", 32'(expected), 0);
        chk("lit_wrap_pulse", 32'(wrap_pulse), 1);
        drive(0, 0, 0, 0, 1, 0);
        chk("lit_wrap_once", 32'(wrap_pulse), 0);
        drive(0, 1, 0, 1, 1, 0);
        chk("lit_load0_nowrap", 32'(wrap_pulse), 0);

        // single glitch: 9 where 7 is expected
        drive(0, 1, 6, 0, 1, 0);
        drive(0, 0, 0, 6, 1, 0);
        drive(0, 0, 0, 9, 1, 0);
        chk("lit_glitch_mis", 32'(mismatch), 1);
        chk("lit_glitch_err", 32'(err_count), 1);
        chk("lit_glitch_sticky", 32'(err_sticky), 1);
        drive(0, 0, 0, 10, 1, 0);
        chk("lit_glitch_once", 32'(mismatch), 0);

        // persistent fault: count stuck at 3
        drive(0, 0, 0, 11, 1, 0);
        drive(0, 0, 0, 3, 1, 0);
        drive(0, 0, 0, 3, 1, 0);
        drive(0, 0, 0, 3, 1, 0);
        chk("lit_resync_state", 32'(state), 2);
        chk("lit_resync_err", 32'(err_count), 4);
        chk("lit_sat2", 32'(s_err_count), 3);
        drive(0, 0, 0, 3, 1, 0);
        chk("lit_resync_back", 32'(state), 1);
        chk("lit_resync_exp", 32'(expected), 4);
        chk("lit_resync_nomis", 32'(mismatch), 0);
        drive(0, 0, 0, 4, 1, 0);
        chk("lit_track_mis", 32'(mismatch), 0);

        // counter reset, load 10, clear coinciding with a mismatch
        drive(1, 0, 0, 5, 1, 0);
        chk("lit_dutrst_exp", 32'(expected), 0);
        chk("lit_dutrst_err", 32'(err_count), 4);
        drive(0, 1, 10, 0, 1, 0);
        drive(0, 0, 0, 10, 1, 0);
        chk("lit_load10_exp", 32'(expected), 11);
        drive(0, 0, 0, 2, 1, 1);
        chk("lit_clr_mis", 32'(mismatch), 1);
        chk("lit_clr_err", 32'(err_count), 0);
        chk("lit_clr_sticky", 32'(err_sticky), 0);

        // asynchronous reset between edges
        drive(0, 0, 0, 3, 1, 0);
        #2 rst = 1'b0;
        #1;
        chk("lit_async_state", 32'(state), 0);
        chk("lit_async_exp", 32'(expected), 0);
        chk("lit_async_err", 32'(err_count), 0);
        @(negedge clk);
        rst = 1'b1;

        // randomized counter traffic with glitches, stalls and disables
        tc = 0;
        stuck = 0;
        stuck_val = 0;
        for (int i = 0; i < 3000; i++) begin
            dr  = ($urandom % 50) == 0;
            ld  = ($urandom % 10) == 0;
            lv  = int'($urandom % 16);
            en  = ($urandom % 40) != 0;
            clr = ($urandom % 60) == 0;
            if (stuck > 0) begin
                cnt = stuck_val;
                stuck--;
            end else if (($urandom % 30) == 0) begin
                stuck = int'($urandom_range(2, 6));
                stuck_val = tc;
                cnt = tc;
            end else if (($urandom % 25) == 0) begin
                cnt = int'($urandom % 16);
            end else begin
                cnt = tc;
            end
            drive(dr, ld, lv, cnt, en, clr);
            tc = dr ? 0 : ld ? lv : (cnt + 1) % 16;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
